// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: arbitrates one shared memory bus between an instruction
// fetch port and a load/store port. A single transaction runs at a time;
// ties alternate between the two requesters, and an access that never sees
// bus_ack is aborted after TIMEOUT_CYCLES bus cycles with a bus_err pulse.
// All outputs except stall come straight from flops.

module cpu_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ready,
  // load/store port
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_byteenable,
  output logic [31:0] data_rdata,
  output logic        data_ready,
  // shared memory bus
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteenable,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  // pipeline freeze
  output logic        stall
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_INST = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Counter value seen in the last bus cycle before the access is abandoned.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_r;
  state_t      next_state_s;

  logic        last_grant_data_r;
  logic        last_grant_data_nxt_s;
  logic [7:0]  cnt_r;
  logic [7:0]  cnt_nxt_s;

  logic        grant_data_s;
  logic        grant_inst_s;
  logic        busy_s;
  logic        timeout_s;

  logic        bus_req_r,        bus_req_nxt_s;
  logic        bus_we_r,         bus_we_nxt_s;
  logic [31:0] bus_addr_r,       bus_addr_nxt_s;
  logic [31:0] bus_wdata_r,      bus_wdata_nxt_s;
  logic [3:0]  bus_be_r,         bus_be_nxt_s;
  logic        bus_err_r,        bus_err_nxt_s;
  logic        inst_ready_r,     inst_ready_nxt_s;
  logic        data_ready_r,     data_ready_nxt_s;
  logic [31:0] inst_rdata_r,     inst_rdata_nxt_s;
  logic [31:0] data_rdata_r,     data_rdata_nxt_s;

  // Grant decision in IDLE plus busy/timeout qualifiers for the bus phase.
  always_comb begin
    grant_data_s = 1'b0;
    grant_inst_s = 1'b0;
    if (state_r == ST_IDLE) begin
      // data wins a tie unless it was the previous winner
      if (data_req && (!inst_req || !last_grant_data_r)) begin
        grant_data_s = 1'b1;
      end else if (inst_req) begin
        grant_inst_s = 1'b1;
      end else begin
        grant_data_s = 1'b0;
        grant_inst_s = 1'b0;
      end
    end else begin
      grant_data_s = 1'b0;
      grant_inst_s = 1'b0;
    end
    busy_s    = (state_r == ST_DATA) || (state_r == ST_INST);
    timeout_s = busy_s && !bus_ack && (cnt_r == TIMEOUT_LAST);
  end

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; DONE always returns to IDLE so every access costs at least 3 cycles.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_data_s) begin
          next_state_s = ST_DATA;
        end else if (grant_inst_s) begin
          next_state_s = ST_INST;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_DATA, ST_INST: begin
        if (bus_ack || timeout_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered bus command, ready pulses, rdata and counter.
  always_comb begin
    bus_req_nxt_s         = 1'b0;
    bus_we_nxt_s          = bus_we_r;
    bus_addr_nxt_s        = bus_addr_r;
    bus_wdata_nxt_s       = bus_wdata_r;
    bus_be_nxt_s          = bus_be_r;
    bus_err_nxt_s         = 1'b0;
    inst_ready_nxt_s      = 1'b0;
    data_ready_nxt_s      = 1'b0;
    inst_rdata_nxt_s      = inst_rdata_r;
    data_rdata_nxt_s      = data_rdata_r;
    last_grant_data_nxt_s = last_grant_data_r;
    cnt_nxt_s             = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_data_s) begin
          bus_req_nxt_s         = 1'b1;
          bus_we_nxt_s          = data_we;
          bus_addr_nxt_s        = data_addr;
          bus_wdata_nxt_s       = data_wdata;
          bus_be_nxt_s          = data_byteenable;
          last_grant_data_nxt_s = 1'b1;
          cnt_nxt_s             = 8'd0;
        end else if (grant_inst_s) begin
          bus_req_nxt_s         = 1'b1;
          bus_we_nxt_s          = 1'b0;
          bus_addr_nxt_s        = inst_addr;
          bus_wdata_nxt_s       = 32'd0;
          bus_be_nxt_s          = 4'b1111;
          last_grant_data_nxt_s = 1'b0;
          cnt_nxt_s             = 8'd0;
        end else begin
          bus_req_nxt_s = 1'b0;
        end
      end
      ST_DATA, ST_INST: begin
        if (bus_ack) begin
          // stores capture too; the requester simply ignores the word
          if (state_r == ST_DATA) begin
            data_rdata_nxt_s = bus_rdata;
            data_ready_nxt_s = 1'b1;
          end else begin
            inst_rdata_nxt_s = bus_rdata;
            inst_ready_nxt_s = 1'b1;
          end
        end else if (timeout_s) begin
          bus_err_nxt_s = 1'b1;
          if (state_r == ST_DATA) begin
            data_rdata_nxt_s = 32'd0;
            data_ready_nxt_s = 1'b1;
          end else begin
            inst_rdata_nxt_s = 32'd0;
            inst_ready_nxt_s = 1'b1;
          end
        end else begin
          bus_req_nxt_s = 1'b1;
          cnt_nxt_s     = cnt_r + 8'd1;
        end
      end
      ST_DONE: begin
        bus_req_nxt_s = 1'b0;
      end
      default: begin
        bus_req_nxt_s = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_r         <= 1'b0;
      bus_we_r          <= 1'b0;
      bus_addr_r        <= 32'd0;
      bus_wdata_r       <= 32'd0;
      bus_be_r          <= 4'b0000;
      bus_err_r         <= 1'b0;
      inst_ready_r      <= 1'b0;
      data_ready_r      <= 1'b0;
      inst_rdata_r      <= 32'd0;
      data_rdata_r      <= 32'd0;
      last_grant_data_r <= 1'b0;
      cnt_r             <= 8'd0;
    end else begin
      bus_req_r         <= bus_req_nxt_s;
      bus_we_r          <= bus_we_nxt_s;
      bus_addr_r        <= bus_addr_nxt_s;
      bus_wdata_r       <= bus_wdata_nxt_s;
      bus_be_r          <= bus_be_nxt_s;
      bus_err_r         <= bus_err_nxt_s;
      inst_ready_r      <= inst_ready_nxt_s;
      data_ready_r      <= data_ready_nxt_s;
      inst_rdata_r      <= inst_rdata_nxt_s;
      data_rdata_r      <= data_rdata_nxt_s;
      last_grant_data_r <= last_grant_data_nxt_s;
      cnt_r             <= cnt_nxt_s;
    end
  end

  assign bus_req        = bus_req_r;
  assign bus_we         = bus_we_r;
  assign bus_addr       = bus_addr_r;
  assign bus_wdata      = bus_wdata_r;
  assign bus_byteenable = bus_be_r;
  assign bus_err        = bus_err_r;
  assign inst_ready     = inst_ready_r;
  assign data_ready     = data_ready_r;
  assign inst_rdata     = inst_rdata_r;
  assign data_rdata     = data_rdata_r;

  // stall is the only combinational output: it must drop in the ready cycle itself
  assign stall = (inst_req & ~inst_ready_r) | (data_req & ~data_ready_r);

  cpu_mem_arbiter_checker u_checker (
    .clk        (clk),
    .rst        (rst),
    .inst_ready (inst_ready_r),
    .data_ready (data_ready_r),
    .bus_req    (bus_req_r),
    .bus_err    (bus_err_r)
  );

endmodule

// cpu_mem_arbiter_checker: protocol properties of the arbiter outputs.
module cpu_mem_arbiter_checker (
  input logic clk,
  input logic rst,
  input logic inst_ready,
  input logic data_ready,
  input logic bus_req,
  input logic bus_err
);

  // only one requester completes per cycle
  a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
    !(inst_ready && data_ready));

  // ready is a single-cycle pulse
  a_inst_pulse: assert property (@(posedge clk) inst_ready |=> !inst_ready);
  a_data_pulse: assert property (@(posedge clk) data_ready |=> !data_ready);

  // an abort still completes the access towards the requester
  a_err_ready: assert property (@(posedge clk) disable iff (rst)
    bus_err |-> (inst_ready || data_ready));

  // reset clears the bus and suppresses completion
  a_rst_quiet: assert property (@(posedge clk)
    rst |=> (!bus_req && !bus_err && !inst_ready && !data_ready));

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed self-checking bench for cpu_mem_arbiter (TIMEOUT_CYCLES = 4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = 32'd0;
  logic [31:0] inst_rdata;
  logic        inst_ready;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = 32'd0;
  logic [31:0] data_wdata = 32'd0;
  logic [3:0]  data_byteenable = 4'b0000;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_rdata = 32'd0;
  logic        bus_ack = 1'b0;
  logic        bus_err;
  logic        stall;

  int vectors = 0;
  int miscompares = 0;

  cpu_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_rdata      (inst_rdata),
    .inst_ready      (inst_ready),
    .data_req        (data_req),
    .data_we         (data_we),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_byteenable (data_byteenable),
    .data_rdata      (data_rdata),
    .data_ready      (data_ready),
    .bus_req         (bus_req),
    .bus_we          (bus_we),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_byteenable  (bus_byteenable),
    .bus_rdata       (bus_rdata),
    .bus_ack         (bus_ack),
    .bus_err         (bus_err),
    .stall           (stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    chk1 ("rst_bus_req",    bus_req,    1'b0);
    chk1 ("rst_inst_ready", inst_ready, 1'b0);
    chk1 ("rst_data_ready", data_ready, 1'b0);
    chk1 ("rst_bus_err",    bus_err,    1'b0);
    chk32("rst_inst_rdata", inst_rdata, 32'd0);
    chk32("rst_data_rdata", data_rdata, 32'd0);
    chk32("rst_bus_addr",   bus_addr,   32'd0);
    chk1 ("rst_stall",      stall,      1'b0);
    rst = 1'b0;
    tick();

    // ---------------- single load, ack in 2nd bus cycle ----------------
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0100;
    data_byteenable = 4'b0001; data_wdata = 32'd0;
    #1;
    chk1 ("ld_stall_idle", stall, 1'b1);
    tick();                                   // bus cycle 1
    chk1 ("ld_bus_req1",  bus_req,  1'b1);
    chk32("ld_bus_addr",  bus_addr, 32'h0000_0100);
    chk1 ("ld_bus_we",    bus_we,   1'b0);
    chk32("ld_bus_be",    {28'd0, bus_byteenable}, 32'h0000_0001);
    chk1 ("ld_stall1",    stall,    1'b1);
    tick();                                   // bus cycle 2
    chk1 ("ld_bus_req2",  bus_req,  1'b1);
    chk1 ("ld_ready_early", data_ready, 1'b0);
    bus_ack = 1'b1; bus_rdata = 32'hAABB_CCDD;
    tick();                                   // DONE
    bus_ack = 1'b0;
    chk1 ("ld_ready",     data_ready, 1'b1);
    chk32("ld_rdata",     data_rdata, 32'hAABB_CCDD);
    chk1 ("ld_bus_req_done", bus_req, 1'b0);
    chk1 ("ld_stall_done", stall,     1'b0);
    chk1 ("ld_inst_ready", inst_ready, 1'b0);
    data_req = 1'b0;
    tick();                                   // IDLE
    chk1 ("ld_ready_pulse", data_ready, 1'b0);
    chk32("ld_rdata_hold",  data_rdata, 32'hAABB_CCDD);

    // ---------------- store ----------------
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0000_0204;
    data_wdata = 32'h0000_5A00; data_byteenable = 4'b0010;
    tick();
    chk1 ("st_bus_we",    bus_we,    1'b1);
    chk32("st_bus_be",    {28'd0, bus_byteenable}, 32'h0000_0002);
    chk32("st_bus_wdata", bus_wdata, 32'h0000_5A00);
    chk32("st_bus_addr",  bus_addr,  32'h0000_0204);
    data_wdata = 32'hFFFF_FFFF;              // command must stay latched
    tick();
    chk32("st_wdata_held", bus_wdata, 32'h0000_5A00);
    chk1 ("st_we_held",    bus_we,    1'b1);
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    bus_ack = 1'b0;
    chk1 ("st_ready", data_ready, 1'b1);
    chk32("st_rdata", data_rdata, 32'h1234_5678);
    data_req = 1'b0; data_we = 1'b0;
    tick();

    // ---------------- fetch, then fetch that times out ----------------
    inst_req = 1'b1; inst_addr = 32'h0000_0040;
    tick();
    chk32("if_bus_addr",  bus_addr,  32'h0000_0040);
    chk1 ("if_bus_we",    bus_we,    1'b0);
    chk32("if_bus_be",    {28'd0, bus_byteenable}, 32'h0000_000F);
    chk32("if_bus_wdata", bus_wdata, 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    tick();
    bus_ack = 1'b0;
    chk1 ("if_ready", inst_ready, 1'b1);
    chk32("if_rdata", inst_rdata, 32'hCAFE_F00D);
    chk1 ("if_data_ready", data_ready, 1'b0);
    inst_addr = 32'h0000_0044;
    tick();                                   // IDLE, grant sampled here
    chk1 ("to_idle_req", bus_req, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();                                 // bus cycles 1..4, no ack
      chk1 ("to_bus_req", bus_req, 1'b1);
      chk1 ("to_no_err",  bus_err, 1'b0);
    end
    tick();                                   // DONE after abort
    chk1 ("to_bus_err",  bus_err,    1'b1);
    chk1 ("to_ready",    inst_ready, 1'b1);
    chk32("to_rdata",    inst_rdata, 32'd0);
    chk1 ("to_bus_req_off", bus_req, 1'b0);
    inst_req = 1'b0;
    tick();
    chk1 ("to_err_pulse",   bus_err,    1'b0);
    chk1 ("to_ready_pulse", inst_ready, 1'b0);
    chk1 ("to_idle",        bus_req,    1'b0);

    // ---------------- reset in DATA ----------------
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0300;
    data_byteenable = 4'b1111;
    tick();
    chk1 ("rd_bus_req", bus_req, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1 ("rd_bus_req_off", bus_req,    1'b0);
    chk1 ("rd_no_ready",    data_ready, 1'b0);
    chk1 ("rd_no_err",      bus_err,    1'b0);
    chk32("rd_data_rdata",  data_rdata, 32'd0);
    tick();                                   // fresh grant
    chk1 ("rd_regrant",   bus_req,  1'b1);
    chk32("rd_bus_addr",  bus_addr, 32'h0000_0300);
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_BEEF;
    tick();
    bus_ack = 1'b0;
    chk1 ("rd_ready", data_ready, 1'b1);
    chk32("rd_rdata", data_rdata, 32'h0BAD_BEEF);
    data_req = 1'b0;
    tick();

    // ---------------- tie after reset, then alternation ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_0080;
    data_req = 1'b1; data_addr = 32'h0000_0400; data_we = 1'b0;
    tick();
    chk32("tie1_addr", bus_addr, 32'h0000_0400);
    bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    tick();
    bus_ack = 1'b0;
    chk1 ("tie1_data_ready", data_ready, 1'b1);
    chk1 ("tie1_inst_ready", inst_ready, 1'b0);
    data_addr = 32'h0000_0404;
    tick();
    tick();
    chk32("tie2_addr", bus_addr, 32'h0000_0080);
    chk32("tie2_be",   {28'd0, bus_byteenable}, 32'h0000_000F);
    bus_ack = 1'b1; bus_rdata = 32'h2222_2222;
    tick();
    bus_ack = 1'b0;
    chk1 ("tie2_inst_ready", inst_ready, 1'b1);
    chk1 ("tie2_data_ready", data_ready, 1'b0);
    chk32("tie2_rdata",      inst_rdata, 32'h2222_2222);
    chk1 ("tie2_stall",      stall,      1'b1);
    inst_addr = 32'h0000_0084;
    tick();
    tick();
    chk32("tie3_addr", bus_addr, 32'h0000_0404);
    bus_ack = 1'b1; bus_rdata = 32'h3333_3333;
    tick();
    bus_ack = 1'b0;
    chk1 ("tie3_data_ready", data_ready, 1'b1);
    chk32("tie3_rdata",      data_rdata, 32'h3333_3333);
    tick();
    tick();
    chk32("tie4_addr", bus_addr, 32'h0000_0084);
    bus_ack = 1'b1; bus_rdata = 32'h4444_4444;
    tick();
    bus_ack = 1'b0;
    chk1 ("tie4_inst_ready", inst_ready, 1'b1);
    inst_req = 1'b0; data_req = 1'b0;
    tick();

    // ---------------- spurious ack in IDLE ----------------
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_DEAD;
    tick();
    chk1 ("sp_inst_ready", inst_ready, 1'b0);
    chk1 ("sp_data_ready", data_ready, 1'b0);
    chk1 ("sp_bus_req",    bus_req,    1'b0);
    tick();
    chk32("sp_inst_rdata", inst_rdata, 32'h4444_4444);
    chk32("sp_data_rdata", data_rdata, 32'h3333_3333);
    chk1 ("sp_inst_ready2", inst_ready, 1'b0);
    bus_ack = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, bus cycles waited for bus_ack before an aborted access; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 inst_req  input  1  fetch request; held high until inst_ready.
REQ-005 inst_addr  input  32  fetch address, word-aligned; stable while inst_req high.
REQ-006 inst_rdata  output  32  fetched word; valid when inst_ready=1.
REQ-007 inst_ready  output  1  one-cycle completion pulse for fetch.
REQ-008 data_req  input  1  load/store request; held high until data_ready.
REQ-009 data_we  input  1  1=store, 0=load.
REQ-010 data_addr  input  32  data address; stable while data_req high.
REQ-011 data_wdata  input  32  store data, already lane-aligned.
REQ-012 data_byteenable  input  4  active byte lanes (0001,0010,0100,1000,0011,1100,1111).
REQ-013 data_rdata  output  32  raw load word, unshifted, unextended; valid when data_ready=1.
REQ-014 data_ready  output  1  one-cycle completion pulse for load/store.
REQ-015 bus_req  output  1  bus transaction active.
REQ-016 bus_we, bus_addr[31:0], bus_wdata[31:0], bus_byteenable[3:0]  output  registered bus command, stable for whole transaction.
REQ-017 bus_rdata  input  32  bus read data, valid in bus_ack cycle.
REQ-018 bus_ack  input  1  one-cycle bus completion.
REQ-019 bus_err  output  1  one-cycle pulse on timeout abort.
REQ-020 stall  output  1  pipeline freeze = (inst_req & ~inst_ready) | (data_req & ~data_ready), combinational.

Function
REQ-021 FSM states: IDLE, DATA, INST, DONE.
REQ-022 IDLE, no request: bus_req=0; stay.
REQ-023 IDLE, one request: grant it; latch command into bus registers; go DATA or INST; clear timeout counter.
REQ-024 IDLE, both requests: grant data unless last_grant=data, then grant inst; last_grant updated on every grant.
REQ-025 Fetch grant drives bus_we=0, bus_byteenable=1111, bus_wdata=0, bus_addr=inst_addr.
REQ-026 DATA/INST: bus_req=1, command held; counter increments each cycle without bus_ack.
REQ-027 bus_ack=1 in DATA/INST: capture bus_rdata into the granted requester's rdata register (stores capture too, ignored); go DONE.
REQ-028 Counter reaching TIMEOUT_CYCLES with no ack: rdata register <= 0; bus_err=1 for one cycle; go DONE.
REQ-029 DONE: bus_req=0; granted requester's ready=1 for exactly this cycle; next state IDLE unconditionally.
REQ-030 Latency: request sampled in IDLE cycle N -> bus_req from N+1 -> ack earliest N+1 -> ready N+2 -> next grant earliest N+3 (minimum 3 cycles per access).
REQ-031 bus_ack in IDLE or DONE is ignored; never generates ready.
REQ-032 rdata outputs retain last captured value between transactions.
REQ-033 A request dropped mid-transaction does not abort it; transaction completes; ready still pulses.
REQ-034 inst_ready and data_ready never high in the same cycle.

Reset
REQ-035 rst=1 at an edge: state=IDLE, last_grant=inst (so data wins first tie), counter=0, all outputs except stall =0, rdata registers=0.
REQ-036 Reset mid-transaction abandons it: no ready, no bus_err; bus_req=0 the cycle after the reset edge.

Verification
REQ-037 Single load: data_req, we=0, addr=0x100, be=0001; bus_ack at 2nd bus cycle with bus_rdata=0xAABBCCDD -> data_rdata=0xAABBCCDD, data_ready one pulse, stall high until that pulse.
REQ-038 Tie: inst_req and data_req together after reset -> data granted first, inst second; then hold both -> grants alternate inst/data.
REQ-039 Store: we=1, addr=0x204, wdata=0x00005A00, be=0010 -> bus_we=1, bus_byteenable=0010, bus_wdata=0x00005A00 held until ack.
REQ-040 Timeout with TIMEOUT_CYCLES=4, no ack -> bus_err pulse after 4 bus cycles; inst_rdata=0; inst_ready pulses; FSM back to IDLE.
REQ-041 rst asserted while in DATA -> no data_ready; bus_req=0 next cycle; a new request afterwards completes normally.
REQ-042 Spurious bus_ack in IDLE -> no ready pulse; outputs unchanged.
